// File: rtl/p12_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// p12_cfg_sequencer
//
// Drives a CHAIN_LEN-bit configuration scan chain through one sequence:
//   IDLE -> PREP -> SHIFT -> FINISH -> DONE -> IDLE
//
// Write mode (mode=0): bytes from the in_* stream are shifted into the chain
// LSB first via sc. Readback mode (mode=1): the chain output is fed straight
// back into sc, so the chain recirculates and keeps its contents.
// In both modes every shifted bit of out_sc is collected LSB first into
// bytes that are delivered on the out_* stream.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start, mode         request a sequence (sampled in IDLE), 0=write 1=readback
//   abort               stop a running sequence (PREP/SHIFT only)
//   in_data/valid/ready write-byte stream (sink)
//   out_data/valid/ready readback-byte stream (source)
//   busy, done, aborted status
//   se, sc              grid scan enable / scan data
//   ff_gate, l_gate     grid flop gate / latch gate
//   out_sc              grid scan-chain output
//
// CHAIN_LEN must be a multiple of 8 and at least 16.
// ---------------------------------------------------------------------------
module p12_cfg_sequencer #(
  parameter int unsigned CHAIN_LEN = 432
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  input  logic       abort,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic       se,
  output logic       sc,
  output logic       ff_gate,
  output logic       l_gate,
  input  logic       out_sc
);

  localparam int unsigned NBYTES = CHAIN_LEN / 8;
  localparam int unsigned BW     = $clog2(CHAIN_LEN + 1);
  localparam int unsigned YW     = $clog2(NBYTES + 1);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    SHIFT,
    FINISH,
    DONE
  } state_e;

  state_e          state_q,     state_d;
  logic            mode_q,      mode_d;
  logic [7:0]      buf_q,       buf_d;        // write bit buffer, bit 0 is next out
  logic [3:0]      buf_cnt_q,   buf_cnt_d;    // bits left in buf_q (0..8)
  logic [7:0]      acc_q,       acc_d;        // readback accumulator
  logic [2:0]      acc_cnt_q,   acc_cnt_d;    // bits held in acc_q (0..7)
  logic [7:0]      out_data_q,  out_data_d;
  logic            out_valid_q, out_valid_d;
  logic [BW-1:0]   bit_cnt_q,   bit_cnt_d;    // shift cycles so far
  logic [YW-1:0]   byte_cnt_q,  byte_cnt_d;   // write bytes accepted so far
  logic            aborted_q,   aborted_d;

  logic            bit_avail;
  logic            stall;
  logic            shift_en;
  logic            accept;
  logic            last_bit;
  logic            abort_hit;

  // A bit is always available in readback because the chain feeds itself.
  assign bit_avail = mode_q | (buf_cnt_q != 4'd0);

  // Capturing another bit would need a free output register: with 7 bits
  // already collected and the previous byte still unclaimed, hold the chain.
  assign stall     = (acc_cnt_q == 3'd7) && out_valid_q && !out_ready;

  assign shift_en  = (state_q == SHIFT) && bit_avail && !stall;
  assign last_bit  = shift_en && (bit_cnt_q == BW'(CHAIN_LEN - 1));
  assign abort_hit = abort && ((state_q == PREP) || (state_q == SHIFT));
  assign accept    = in_valid && in_ready;

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign aborted   = aborted_q;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    buf_d       = buf_q;
    buf_cnt_d   = buf_cnt_q;
    acc_d       = acc_q;
    acc_cnt_d   = acc_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    aborted_d   = aborted_q;

    busy     = 1'b0;
    done     = 1'b0;
    se       = 1'b0;
    sc       = 1'b0;
    ff_gate  = 1'b0;
    l_gate   = 1'b0;
    in_ready = 1'b0;

    if ((state_q == SHIFT) && !mode_q && (buf_cnt_q == 4'd0) &&
        (byte_cnt_q < YW'(NBYTES))) begin
      in_ready = 1'b1;
    end

    // Output handshake first so that a byte completing in the same cycle
    // (set below) wins over the clear.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (shift_en) begin
      bit_cnt_d = bit_cnt_q + BW'(1);
      acc_d[acc_cnt_q] = out_sc;
      if (acc_cnt_q == 3'd7) begin
        out_data_d  = {out_sc, acc_q[6:0]};
        out_valid_d = 1'b1;
        acc_cnt_d   = 3'd0;
      end else begin
        acc_cnt_d = acc_cnt_q + 3'd1;
      end
      if (!mode_q) begin
        buf_d     = buf_q >> 1;
        buf_cnt_d = buf_cnt_q - 4'd1;
      end
    end

    // Only possible with an empty buffer, so never collides with a shift.
    if (accept) begin
      buf_d      = in_data;
      buf_cnt_d  = 4'd8;
      byte_cnt_d = byte_cnt_q + YW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d     = mode;
          aborted_d  = 1'b0;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          acc_d      = '0;
          acc_cnt_d  = '0;
          buf_d      = '0;
          buf_cnt_d  = '0;
          state_d    = PREP;
        end
      end
      PREP: begin
        busy    = 1'b1;
        l_gate  = 1'b1;
        ff_gate = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        busy    = 1'b1;
        l_gate  = 1'b1;
        se      = 1'b1;
        ff_gate = !shift_en;
        if (mode_q) begin
          sc = out_sc;
        end else begin
          sc = shift_en & buf_q[0];
        end
        if (last_bit) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        busy    = 1'b1;
        l_gate  = 1'b1;
        ff_gate = 1'b1;
        if (!out_valid_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides both the completion path and any byte just produced.
    if (abort_hit) begin
      state_d     = FINISH;
      acc_d       = '0;
      acc_cnt_d   = '0;
      buf_d       = '0;
      buf_cnt_d   = '0;
      out_valid_d = 1'b0;
      aborted_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      buf_q       <= '0;
      buf_cnt_q   <= '0;
      acc_q       <= '0;
      acc_cnt_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      buf_q       <= buf_d;
      buf_cnt_q   <= buf_cnt_d;
      acc_q       <= acc_d;
      acc_cnt_q   <= acc_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      aborted_q   <= aborted_d;
    end
  end

endmodule

// File: doc/p12_cfg_sequencer.md
P12_CFG_SEQUENCER -- requirements
Module: p12_cfg_sequencer

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 432: scan-chain length in bits; legal values are multiples of 8 and at least 16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request a configuration sequence.
REQ-005 SHALL have port mode, input, 1 bit: 0 = write new configuration, 1 = readback-only (recirculate the chain).
REQ-006 SHALL have port abort, input, 1 bit: synchronous abort of a running sequence.
REQ-007 SHALL have ports in_data (input, 8 bits), in_valid (input, 1 bit) and in_ready (output, 1 bit): write-byte stream.
REQ-008 SHALL have ports out_data (output, 8 bits), out_valid (output, 1 bit) and out_ready (input, 1 bit): readback-byte stream.
REQ-009 SHALL have ports busy, done and aborted, each output, 1 bit: status.
REQ-010 SHALL have ports se, sc, ff_gate and l_gate, each output, 1 bit: grid scan enable, scan data, flop gate and latch gate.
REQ-011 SHALL have port out_sc, input, 1 bit: grid scan-chain output.

Function
REQ-012 SHALL implement the states IDLE, PREP, SHIFT, FINISH and DONE.
REQ-013 In IDLE, start=1 SHALL latch mode and move to PREP on the next edge; start in any other state SHALL be ignored.
REQ-014 PREP SHALL last exactly 1 cycle with busy=1, l_gate=1, ff_gate=1, se=0, then go to SHIFT.
REQ-015 In SHIFT: busy=1, l_gate=1, se=1.
REQ-016 In SHIFT, a shift cycle occurs iff a bit is available and the readback path is not stalled; in a shift cycle ff_gate=0, otherwise ff_gate=1 (chain frozen).
REQ-017 A bit is available in write mode iff the input bit buffer is non-empty; in readback mode a bit is always available and sc=out_sc.
REQ-018 Write mode SHALL shift in_data LSB first; sc = current buffer bit during a shift cycle and 0 otherwise.
REQ-019 in_ready=1 iff state=SHIFT, mode=0, the bit buffer is empty and fewer than CHAIN_LEN/8 bytes have been accepted.
REQ-020 A byte is accepted on in_valid&in_ready; its bits are first available on the next cycle (maximum throughput 8 bits per 9 cycles).
REQ-021 Every shift cycle SHALL capture out_sc into an 8-bit accumulator LSB first; the first captured bit lands in out_data[0].
REQ-022 When the 8th bit is captured, the accumulator SHALL move to out_data and out_valid SHALL be 1 from the next cycle.
REQ-023 out_valid SHALL clear on out_valid&out_ready; out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-024 Readback stall SHALL apply iff the accumulator holds 7 bits, out_valid=1 and out_ready=0; a simultaneous handshake removes the stall.
REQ-025 A bit counter SHALL count shift cycles; the CHAIN_LEN-th shift cycle moves SHIFT to FINISH.
REQ-026 FINISH: se=0, ff_gate=1, l_gate=1, busy=1; remain in FINISH until out_valid=0, then go to DONE.
REQ-027 DONE SHALL last 1 cycle with done=1, busy=0, all gates 0, then go to IDLE.
REQ-028 In IDLE, se, sc, ff_gate, l_gate, in_ready and busy SHALL all be 0.
REQ-029 abort=1 in PREP or SHIFT SHALL go to FINISH next cycle, clear the accumulator, bit buffer and out_valid, and set aborted; aborted stays 1 until the next accepted start.
REQ-030 abort in IDLE, FINISH or DONE SHALL be ignored; abort takes priority over completion when both occur in the same cycle.
REQ-031 Write-mode bytes presented beyond CHAIN_LEN/8 SHALL never be accepted.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, with all outputs 0, out_data=0, counters and buffers cleared and aborted=0.
REQ-033 Reset mid-sequence SHALL leave grid contents undefined; no recovery is required.

Verification (CHAIN_LEN=16)
REQ-034 Write, out_ready=1: start, mode=0, bytes 0xA5 then 0x3C, out_sc driven with pattern 0x0F,0xF0 -> sc sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; out_data 0x0F then 0xF0; done pulses once; exactly 16 cycles with se=1 and ff_gate=0.
REQ-035 Readback, mode=1, out_sc fed by a 16-bit loop model preloaded with 0x1234 -> out bytes 0x34 then 0x12; model contents unchanged; SHIFT lasts exactly 16 cycles.
REQ-036 Backpressure: out_ready=0 until after the 2nd byte -> shifting freezes at 15 bits (ff_gate=1, se=1); after out_ready=1 the sequence completes with correct bytes; FINISH waits for out_valid=0.
REQ-037 Abort after 5 shift cycles -> FINISH next cycle, out_valid=0, then done=1 with aborted=1; the next start clears aborted.
REQ-038 rst_n pulsed low mid-SHIFT -> all outputs 0 asynchronously; a following start runs a full correct write sequence.
